// File: rtl/up2_sw_stack.sv
// LIFO register stack driven by board switches, with registered top, level and sticky error flags.
// Define UP2_STACK_SYNC_EN to treat push/pop as asynchronous levels (synchronised, one op per rise).
module up2_sw_stack #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);

  localparam int AW = $clog2(DEPTH);

  logic             ps;
  logic             pp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    below_idx;
  logic             ovf_set;
  logic             udf_set;
  logic             is_full;
  logic             is_empty;

`ifdef UP2_STACK_SYNC_EN
  logic [1:0] push_s;
  logic [1:0] pop_s;
  logic       push_p;
  logic       pop_p;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      push_s <= '0;
      pop_s  <= '0;
      push_p <= 1'b0;
      pop_p  <= 1'b0;
    end else begin
      push_s <= {push_s[0], push};
      pop_s  <= {pop_s[0], pop};
      push_p <= push_s[1];
      pop_p  <= pop_s[1];
    end
  end

  assign ps = push_s[1] & ~push_p;
  assign pp = pop_s[1] & ~pop_p;
`else
  assign ps = push;
  assign pp = pop;
`endif

  assign is_full   = (count == CW'(DEPTH));
  assign is_empty  = (count == '0);
  assign top_idx   = AW'(count - CW'(1));
  assign below_idx = AW'(count - CW'(2));

  always_comb begin
    cnt_nxt  = count;
    dout_nxt = dout;
    wr_en    = 1'b0;
    wr_idx   = count[AW-1:0];
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    unique case (1'b1)
      ps & ~pp: begin
        if (!is_full) begin
          wr_en    = 1'b1;
          cnt_nxt  = count + CW'(1);
          dout_nxt = din;
        end else begin
          ovf_set = 1'b1;
        end
      end
      pp & ~ps: begin
        if (!is_empty) begin
          cnt_nxt  = count - CW'(1);
          dout_nxt = (count == CW'(1)) ? '0 : mem[below_idx];
        end else begin
          udf_set = 1'b1;
        end
      end
      ps & pp: begin
        wr_en    = 1'b1;
        dout_nxt = din;
        if (!is_empty) begin
          wr_idx = top_idx;
        end else begin
          // empty: acts as a plain push but still flags the pop
          cnt_nxt = CW'(1);
          udf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      dout  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_en) mem[wr_idx] <= din;
      dout  <= dout_nxt;
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CW'(DEPTH));
      ovf   <= ovf_set | (ovf & ~clr_err);
      udf   <= udf_set | (udf & ~clr_err);
    end
  end

endmodule
